// File: rtl/cpu_ctrl_fsm_p.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/writeback sequencing with
// ALU timeout trap, sticky halt/trap and a retired-instruction counter.
module cpu_ctrl_fsm_p #(
   parameter int NREG    = 4,
   parameter int ALU_TMO = 15,
   parameter int CNT_W   = 16,
   localparam int RW     = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [3:0]       opcode,
   input  logic [RW-1:0]    rd,
   input  logic             alu_end,
   input  logic             zero_flag,
   output logic             en_fetch,
   output logic             en_pc,
   output logic [1:0]       pc_ctrl,
   output logic             en_group,
   output logic             alu_in_sel,
   output logic [2:0]       alu_func,
   output logic [NREG-1:0]  reg_en,
   output logic [3:0]       state,
   output logic             halted,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_EXEC   = 4'd3;
   localparam logic [3:0] S_JUMP   = 4'd4;
   localparam logic [3:0] S_JZ     = 4'd5;
   localparam logic [3:0] S_WB     = 4'd6;
   localparam logic [3:0] S_HALT   = 4'd7;
   localparam logic [3:0] S_TRAP   = 4'd8;

   localparam logic [3:0] OP_MOVEB = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0101;
   localparam logic [3:0] OP_AND   = 4'b0111;
   localparam logic [3:0] OP_OR    = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1010;
   localparam logic [3:0] OP_JZ    = 4'b1011;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam logic [7:0] TMO_LAST = 8'(ALU_TMO - 1);

   logic [3:0]       r_state;
   logic [3:0]       w_next;
   logic [3:0]       r_op;
   logic [RW-1:0]    r_rd;
   logic [7:0]       r_cnt;
   logic [CNT_W-1:0] r_retired;
   logic             w_rd_bad;

   // only reachable when NREG is not a power of two
   assign w_rd_bad = (int'(rd) >= NREG);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH:  if (instr_valid) w_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_MOVEB, OP_ADD, OP_SUB, OP_AND, OP_OR:
                          w_next = w_rd_bad ? S_TRAP : S_EXEC;
               OP_JMP:    w_next = S_JUMP;
               OP_JZ:     w_next = S_JZ;
               OP_HALT:   w_next = S_HALT;
               default:   w_next = S_TRAP;
            endcase
         end
         S_EXEC: begin
            if (alu_end)                w_next = S_WB;
            else if (r_cnt == TMO_LAST) w_next = S_TRAP;
         end
         S_JUMP, S_JZ, S_WB: w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_TRAP;
      endcase
   end

   always_comb begin
      en_fetch   = 1'b0;
      en_pc      = 1'b0;
      pc_ctrl    = 2'b00;
      en_group   = 1'b0;
      alu_in_sel = 1'b0;
      alu_func   = 3'b000;
      reg_en     = '0;
      halted     = 1'b0;
      trap       = 1'b0;
      case (r_state)
         S_FETCH: begin
            en_fetch = 1'b1;
            if (instr_valid) begin
               en_pc   = 1'b1;
               pc_ctrl = 2'b01;
            end
         end
         S_EXEC: begin
            en_group = 1'b1;
            case (r_op)
               OP_ADD:  alu_func = 3'b001;
               OP_SUB:  begin alu_func = 3'b010; alu_in_sel = 1'b1; end
               OP_AND:  begin alu_func = 3'b011; alu_in_sel = 1'b1; end
               OP_OR:   begin alu_func = 3'b100; alu_in_sel = 1'b1; end
               default: alu_func = 3'b000;
            endcase
         end
         S_JUMP: begin
            en_pc   = 1'b1;
            pc_ctrl = 2'b10;
         end
         S_JZ: begin
            if (zero_flag) begin
               en_pc   = 1'b1;
               pc_ctrl = 2'b10;
            end
         end
         S_WB:    reg_en = NREG'(1) << r_rd;
         S_HALT:  halted = 1'b1;
         S_TRAP:  trap   = 1'b1;
         default: ;
      endcase
   end

   // operand latches and ALU watchdog; counter is held while alu_end is high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (r_state == S_DECODE) begin
            r_op <= opcode;
            r_rd <= rd;
         end
         if (r_state != S_EXEC && w_next == S_EXEC) r_cnt <= '0;
         else if (r_state == S_EXEC && !alu_end)    r_cnt <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_retired <= '0;
      else if (r_state == S_WB || r_state == S_JUMP || r_state == S_JZ)
         r_retired <= r_retired + CNT_W'(1);
   end

   assign state   = r_state;
   assign retired = r_retired;

endmodule

// File: tb/tb_cpu_ctrl_fsm_p.sv
// Scoreboard bench for cpu_ctrl_fsm_p: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares against two differently sized instances.
module tb_cpu_ctrl_fsm_p;

   typedef struct {
      int          dut;
      logic [34:0] v;
      string       name;
   } exp_t;

   logic       clk;
   logic       rst [2];
   logic       iv  [2];
   logic [3:0] op  [2];
   logic [1:0] rdv [2];
   logic       ae  [2];
   logic       zf  [2];

   logic       efA, epA, egA, aisA, hA, tA;
   logic [1:0] pcA;
   logic [2:0] afA;
   logic [3:0] reA, stA;
   logic [15:0] retA;
   logic       efB, epB, egB, aisB, hB, tB;
   logic [1:0] pcB;
   logic [2:0] afB;
   logic [2:0] reB;
   logic [3:0] stB;
   logic [3:0] retB;

   exp_t q [$];
   int   checks = 0;
   int   errors = 0;
   int   eret [2];

   cpu_ctrl_fsm_p #(.NREG(4), .ALU_TMO(15), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst[0]), .instr_valid(iv[0]), .opcode(op[0]), .rd(rdv[0]),
      .alu_end(ae[0]), .zero_flag(zf[0]), .en_fetch(efA), .en_pc(epA),
      .pc_ctrl(pcA), .en_group(egA), .alu_in_sel(aisA), .alu_func(afA),
      .reg_en(reA), .state(stA), .halted(hA), .trap(tA), .retired(retA));

   cpu_ctrl_fsm_p #(.NREG(3), .ALU_TMO(15), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst[1]), .instr_valid(iv[1]), .opcode(op[1]), .rd(rdv[1]),
      .alu_end(ae[1]), .zero_flag(zf[1]), .en_fetch(efB), .en_pc(epB),
      .pc_ctrl(pcB), .en_group(egB), .alu_in_sel(aisB), .alu_func(afB),
      .reg_en(reB), .state(stB), .halted(hB), .trap(tB), .retired(retB));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   // monitor: one expectation per checked cycle, sampled at negedge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [34:0] act;
         e = q.pop_front();
         if (e.dut == 0)
            act = {stA, efA, epA, pcA, egA, aisA, afA, reA, hA, tA, retA};
         else
            act = {stB, efB, epB, pcB, egB, aisB, afB, {1'b0, reB}, hB, tB, {12'b0, retB}};
         checks++;
         if (act !== e.v) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got st=%0d ctl=%h ret=%0d expected st=%0d ctl=%h ret=%0d",
                     e.name, e.dut, $time, act[34:31], act[30:16], act[15:0],
                     e.v[34:31], e.v[30:16], e.v[15:0]);
         end
      end
   end

   function automatic logic [3:0] alu_exp(input logic [3:0] o);
      case (o)
         4'b0000: alu_exp = {3'b000, 1'b0};
         4'b0010: alu_exp = {3'b001, 1'b0};
         4'b0101: alu_exp = {3'b010, 1'b1};
         4'b0111: alu_exp = {3'b011, 1'b1};
         4'b1001: alu_exp = {3'b100, 1'b1};
         default: alu_exp = 4'b0000;
      endcase
   endfunction

   task automatic push(input int d, input logic [3:0] st, input logic ef, input logic ep,
                       input logic [1:0] pc, input logic eg, input logic ais,
                       input logic [2:0] af, input logic [3:0] re, input string nm);
      exp_t e;
      e.dut  = d;
      e.name = nm;
      e.v    = {st, ef, ep, pc, eg, ais, af, re, (st == 4'd7), (st == 4'd8),
                16'(eret[d]) & ((d == 1) ? 16'h000F : 16'hFFFF)};
      q.push_back(e);
   endtask

   task automatic cyc(input int d, input logic ivv, input logic [3:0] o, input logic [1:0] r,
                      input logic aev, input logic zfv, input logic [3:0] st, input logic ef,
                      input logic ep, input logic [1:0] pc, input logic eg, input logic ais,
                      input logic [2:0] af, input logic [3:0] re, input string nm);
      @(posedge clk);
      #1;
      iv[d] = ivv; op[d] = o; rdv[d] = r; ae[d] = aev; zf[d] = zfv;
      push(d, st, ef, ep, pc, eg, ais, af, re, nm);
   endtask

   task automatic do_reset(input int d, input logic ivv, input logic aev);
      @(posedge clk);
      #1;
      rst[d] = 1'b1; iv[d] = ivv; ae[d] = aev;
      eret[d] = 0;
      push(d, 4'd0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, "reset");
      @(posedge clk);
      #1;
      rst[d] = 1'b0; iv[d] = 1'b0; ae[d] = 1'b0;
      push(d, 4'd0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, "idle");
   endtask

   task automatic fetch(input int d, input logic ivv, input logic [3:0] o, input logic [1:0] r);
      cyc(d, ivv, o, r, 0, 0, 4'd1, 1, ivv, ivv ? 2'b01 : 2'b00, 0, 0, 3'b000, 4'b0000, "fetch");
   endtask

   task automatic still(input int d, input logic [3:0] st, input string nm);
      cyc(d, 0, op[d], rdv[d], 0, 0, st, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, nm);
   endtask

   task automatic exec(input int d, input logic aev);
      logic [3:0] x;
      x = alu_exp(op[d]);
      cyc(d, 0, op[d], rdv[d], aev, 0, 4'd3, 0, 0, 2'b00, 1, x[0], x[3:1], 4'b0000, "exec");
   endtask

   task automatic wb(input int d, input logic [3:0] re);
      cyc(d, 0, op[d], rdv[d], 0, 0, 4'd6, 0, 0, 2'b00, 0, 0, 3'b000, re, "wb");
      eret[d]++;
   endtask

   task automatic jump(input int d);
      cyc(d, 0, op[d], rdv[d], 0, 0, 4'd4, 0, 1, 2'b10, 0, 0, 3'b000, 4'b0000, "jump");
      eret[d]++;
   endtask

   task automatic jz(input int d, input logic zfv);
      cyc(d, 0, op[d], rdv[d], 0, zfv, 4'd5, 0, zfv, zfv ? 2'b10 : 2'b00, 0, 0, 3'b000,
          4'b0000, "jz");
      eret[d]++;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; iv[d] = 0; op[d] = 0; rdv[d] = 0; ae[d] = 0; zf[d] = 0; eret[d] = 0;
      end

      // ADD rd=2, alu_end on 3rd EXEC cycle
      do_reset(0, 0, 0);
      fetch(0, 1, 4'b0010, 2'd2);
      still(0, 4'd2, "decode");
      exec(0, 0); exec(0, 0); exec(0, 1);
      wb(0, 4'b0100);

      // JZ taken then not taken
      fetch(0, 1, 4'b1011, 2'd0);
      still(0, 4'd2, "decode");
      jz(0, 1);
      fetch(0, 1, 4'b1011, 2'd0);
      still(0, 4'd2, "decode");
      jz(0, 0);

      // FETCH stall then SUB that never completes
      for (int i = 0; i < 5; i++) fetch(0, 0, 4'b0101, 2'd1);
      fetch(0, 1, 4'b0101, 2'd1);
      still(0, 4'd2, "decode");
      for (int i = 0; i < 15; i++) exec(0, 0);
      for (int i = 0; i < 3; i++) still(0, 4'd8, "trap_tmo");

      // remaining ALU ops, alu_end in the timeout cycle, JUMP
      do_reset(0, 0, 0);
      fetch(0, 1, 4'b0000, 2'd0); still(0, 4'd2, "decode"); exec(0, 1); wb(0, 4'b0001);
      fetch(0, 1, 4'b0111, 2'd3); still(0, 4'd2, "decode"); exec(0, 1); wb(0, 4'b1000);
      fetch(0, 1, 4'b1001, 2'd1); still(0, 4'd2, "decode"); exec(0, 0); exec(0, 1);
      wb(0, 4'b0010);
      fetch(0, 1, 4'b0010, 2'd3); still(0, 4'd2, "decode");
      for (int i = 0; i < 14; i++) exec(0, 0);
      exec(0, 1);
      wb(0, 4'b1000);
      fetch(0, 1, 4'b1010, 2'd0); still(0, 4'd2, "decode"); jump(0);

      // reset mid-FETCH with instr_valid high, then mid-EXEC with alu_end high
      fetch(0, 0, 4'b0010, 2'd1);
      do_reset(0, 1, 0);
      fetch(0, 1, 4'b0010, 2'd1); still(0, 4'd2, "decode"); exec(0, 0); exec(0, 0);
      do_reset(0, 0, 1);
      fetch(0, 0, 4'b0010, 2'd1);

      // illegal opcode, then HALT held
      fetch(0, 1, 4'b0011, 2'd0); still(0, 4'd2, "decode");
      still(0, 4'd8, "trap_op"); still(0, 4'd8, "trap_op");
      do_reset(0, 0, 0);
      fetch(0, 1, 4'b1111, 2'd0); still(0, 4'd2, "decode");
      for (int i = 0; i < 100; i++) still(0, 4'd7, "halt");

      // NREG=3: rd=3 traps, rd=2 writes bit 2; CNT_W=4 wrap after 16 JUMPs
      do_reset(1, 0, 0);
      fetch(1, 1, 4'b0010, 2'd3); still(1, 4'd2, "decode");
      still(1, 4'd8, "trap_rd"); still(1, 4'd8, "trap_rd");
      do_reset(1, 0, 0);
      fetch(1, 1, 4'b0010, 2'd2); still(1, 4'd2, "decode"); exec(1, 1); wb(1, 4'b0100);
      do_reset(1, 0, 0);
      for (int i = 0; i < 16; i++) begin
         fetch(1, 1, 4'b1010, 2'd0); still(1, 4'd2, "decode"); jump(1);
      end
      fetch(1, 0, 4'b1010, 2'd0);

      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
